// File: rtl/fetch_unit.sv
// Fetch stage: PC register, branch-target LUT and IDLE/RUN/HALT run control.
// One instruction per unstalled cycle; ALUOp/Valid combinational, PC/Done registered; Stall freezes PC and state.
module fetch_unit #(
  parameter int PC_W      = 10,
  parameter int INSTR_W   = 9,
  parameter int OP_W      = 3,
  parameter int LUT_IDX_W = 5,
  parameter logic [INSTR_W-1:0] HALT_INSTR = {INSTR_W{1'b1}}
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Stall,
  input  logic [INSTR_W-1:0]   InstrIn,
  input  logic                 Branch,
  input  logic                 Cond,
  input  logic                 LutWe,
  input  logic [LUT_IDX_W-1:0] LutAddr,
  input  logic [PC_W-1:0]      LutData,
  output logic [PC_W-1:0]      PC,
  output logic [OP_W-1:0]      ALUOp,
  output logic                 Valid,
  output logic                 Done
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t                 state, state_nxt;
  logic [PC_W-1:0]        pc_nxt;
  logic                   done_nxt;
  logic [PC_W-1:0]        lut [2**LUT_IDX_W];
  logic [LUT_IDX_W-1:0]   lut_idx;

  assign lut_idx = InstrIn[LUT_IDX_W-1:0];
  assign ALUOp   = InstrIn[INSTR_W-1 -: OP_W];
  assign Valid   = (state == RUN) && !Stall;

  // Halt outranks branch; a stalled cycle evaluates neither.
  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    done_nxt  = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
        end
      end
      RUN: begin
        if (!Stall) begin
          if (InstrIn == HALT_INSTR) begin
            state_nxt = HALT;
            done_nxt  = 1'b1;
          end else if (Branch && Cond) begin
            pc_nxt = lut[lut_idx];
          end else begin
            pc_nxt = PC + PC_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      PC    <= '0;
      Done  <= 1'b0;
    end else begin
      state <= state_nxt;
      PC    <= pc_nxt;
      Done  <= done_nxt;
    end
  end

  // Branch reads this cycle's contents, so a same-edge write lands one cycle later.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 2**LUT_IDX_W; i++) lut[i] <= '0;
    end else if (LutWe) begin
      lut[LutAddr] <= LutData;
    end
  end

endmodule
